dbctr_core: RTL and testbench
=============================

# dbctr_core

Debounced 4-bit up/down/load counter: the design under test driven by the debounced-counter bench driver and observed by its responder. Each command input (up, down, load) must be sampled high on MIN_HOLD consecutive rising clock edges before it takes effect. It then takes effect exactly once per press, with a one-cycle `ack` pulse that presents the new `counter` value. An asynchronous reset clears the counter and also produces an `ack` pulse after release, so every accepted operation, including reset, yields exactly one acknowledged result.

## Interface
- WIDTH, default 4: counter and load-value width.
- MIN_HOLD, default 4: consecutive high samples a command needs before it fires; legal range is 2 or more.
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- up  input  1  increment button, level.
- down  input  1  decrement button, level.
- load  input  1  load button, level.
- value  input  WIDTH  load argument, sampled on the firing edge.
- counter  output  WIDTH  current count, registered.
- ack  output  1  one-cycle pulse: `counter` holds a new result.

## Operation
- Inputs are synchronous to `clock`; no synchronizers are inside this block.
- Selected command each edge, by priority: load, then down, then up; none when all three are low.
- State machine:
  - IDLE. With no command, stay in IDLE. When a command is selected, go to COUNT with hold_cnt=1 and latch the command as `cmd`.
  - COUNT, selected command equals `cmd`: hold_cnt increments. When hold_cnt reaches MIN_HOLD, fire and go to WAIT_RELEASE.
  - COUNT, no command: return to IDLE, with no effect. This covers a glitch or short press.
  - COUNT, a different command is selected: relatch `cmd`, set hold_cnt=1, stay in COUNT.
  - WAIT_RELEASE. Stay while any of up/down/load is high. Go to IDLE on the first edge where all three are low.
- Fire actions:
  - up: counter+1, modulo 2^WIDTH, so 15 wraps to 0.
  - down: counter-1, modulo 2^WIDTH, so 0 wraps to 15.
  - load: counter=value.
- Firing sets `ack`=1 for exactly one cycle.
- Holding a button longer never re-fires; the button must be released and pressed again.
- hold_cnt is $clog2(MIN_HOLD+1) bits wide and never exceeds MIN_HOLD.
- Asynchronous reset immediately sets:
  - counter=0 and ack=0;
  - hold_cnt=0;
  - state=WAIT_RELEASE;
  - rst_pending=1.
- After reset releases, on the first rising edge, ack=1 for one cycle with counter=0, and rst_pending clears.
  - The reset ack has priority; no fire can occur on that same edge, because the state is WAIT_RELEASE.
- A button held through reset release has no effect until it is released and pressed again.

## Timing
- Reset values: counter=0, ack=0, internal state WAIT_RELEASE.
- Latency: a command first sampled high at edge n fires at edge n+MIN_HOLD-1.
  - At that edge, `counter` updates and `ack` rises.
  - `ack` falls at edge n+MIN_HOLD.
  - A consumer sampling on the edge after firing sees ack=1 together with the new counter.
- A press of exactly MIN_HOLD samples fires; a press of MIN_HOLD-1 samples never fires.
- Minimum spacing between acks from presses is MIN_HOLD+1 cycles, because one release sample is needed.
- Reset asserted in the middle of COUNT discards the press: no ack for it, only the reset ack.
- Reset asserted while ack=1 clears ack asynchronously.
- Reset held for several cycles gives a single ack after release, never one per cycle.
- `value` is don't-care except at the firing edge of a load.

## Test plan
- Reset pulse, then idle: one ack cycle on the first edge after release with counter=0; no further acks for 20 cycles.
- From 0, up held 4 edges: counter=1, ack high for exactly one cycle, 3 edges after the first sample. Up held 3 edges: no ack, counter stays 1.
- down held 4 edges, with counter=0: counter=15, one ack. Then up held 10 edges: counter=0, exactly one ack.
- load held 6 edges with value=9: counter=9, exactly one ack, at the 4th sample. value changed to 3 after the fire edge: counter stays 9.
- up and load raised together, with value=5, held 4 edges: counter=5, because load wins. Then down alone for 2 edges, switched to up for 4 edges: a single increment, to 6.
- up held; reset asserted after 2 samples and released while up is still high: counter=0 with a single reset ack and no increment. After up is released, 1 cycle low, and up held 4 edges: counter=1.

Source files
------------

// File: rtl/dbctr_core.sv
// dbctr_core: debounced up/down/load counter.
// A command fires once after MIN_HOLD consecutive high samples and then
// waits for every button to be released before another press is accepted.
// Reset itself is acknowledged with a single ack on the first edge after
// release, so each accepted operation yields exactly one ack.
module dbctr_core #(
  parameter int WIDTH    = 4,
  parameter int MIN_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] counter,
  output logic             ack
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COUNT        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2,
    CMD_LOAD = 2'd3
  } cmd_t;

  state_t            state, stateNext;
  cmd_t              cmd, cmdNext;
  cmd_t              sel;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic [WIDTH-1:0]  counterNext;
  logic              ackNext;
  logic              rstPending, rstPendingNext;
  logic              anyButton;

  // Pick this edge's command by priority: load, then down, then up.
  always_comb begin
    sel = CMD_NONE;
    if (load)
      sel = CMD_LOAD;
    else if (down)
      sel = CMD_DOWN;
    else if (up)
      sel = CMD_UP;
  end

  assign anyButton = up | down | load;

  // State register; reset parks in WAIT_RELEASE so a held button cannot fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= WAIT_RELEASE;
      cmd        <= CMD_NONE;
      holdCnt    <= '0;
      counter    <= '0;
      ack        <= 1'b0;
      rstPending <= 1'b1;
    end else begin
      state      <= stateNext;
      cmd        <= cmdNext;
      holdCnt    <= holdNext;
      counter    <= counterNext;
      ack        <= ackNext;
      rstPending <= rstPendingNext;
    end
  end

  // Debounce FSM: count matching samples, fire once, then wait for release.
  always_comb begin
    stateNext      = state;
    cmdNext        = cmd;
    holdNext       = holdCnt;
    counterNext    = counter;
    ackNext        = 1'b0;
    rstPendingNext = 1'b0;

    if (rstPending)
      ackNext = 1'b1;

    unique case (state)
      IDLE: begin
        if (sel != CMD_NONE) begin
          stateNext = COUNT;
          cmdNext   = sel;
          holdNext  = HOLD_W'(1);
        end
      end

      COUNT: begin
        if (sel == CMD_NONE) begin
          stateNext = IDLE;
          holdNext  = '0;
        end else if (sel != cmd) begin
          cmdNext  = sel;
          holdNext = HOLD_W'(1);
        end else if (holdCnt == HOLD_W'(MIN_HOLD - 1)) begin
          stateNext = WAIT_RELEASE;
          holdNext  = '0;
          ackNext   = 1'b1;
          case (cmd)
            CMD_UP:   counterNext = counter + WIDTH'(1);
            CMD_DOWN: counterNext = counter - WIDTH'(1);
            CMD_LOAD: counterNext = value;
            default:  counterNext = counter;
          endcase
        end else begin
          holdNext = holdCnt + HOLD_W'(1);
        end
      end

      WAIT_RELEASE: begin
        if (!anyButton)
          stateNext = IDLE;
      end

      default: begin
        stateNext = WAIT_RELEASE;
        holdNext  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dbctr_core.sv
// tb_dbctr_core: directed test of the debounced counter with hand-computed
// expectations for latency, ack count, wrap-around and reset behaviour.
module tb_dbctr_core;

  logic       clock;
  logic       reset;
  logic       up;
  logic       down;
  logic       load;
  logic [3:0] value;
  logic [3:0] counter;
  logic       ack;

  int checks;
  int errors;
  int acks;
  int ackStep;
  int stepNum;

  dbctr_core #(.WIDTH(4), .MIN_HOLD(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .up      (up),
    .down    (down),
    .load    (load),
    .value   (value),
    .counter (counter),
    .ack     (ack)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearAcks();
    acks    = 0;
    ackStep = 0;
    stepNum = 0;
  endtask

  // Drive buttons for n edges, sampling 1 ns after each edge and logging acks.
  task automatic applyStimulus(input logic u, input logic d, input logic l,
                               input logic [3:0] v, input int n);
    up    = u;
    down  = d;
    load  = l;
    value = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      stepNum++;
      if (ack === 1'b1) begin
        acks++;
        ackStep = stepNum;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearAcks();
    up    = 1'b0;
    down  = 1'b0;
    load  = 1'b0;
    value = 4'd0;
    reset = 1'b1;
    #2;
    checkOutput("reset_counter", 32'(counter), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);

    // Reset held several edges: no ack while asserted.
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("reset_held_no_ack", 32'(acks), 32'd0);
    reset = 1'b0;

    // First edge after release gives the reset ack, then silence.
    clearAcks();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_ack_pulse", 32'(ack), 32'd1);
    checkOutput("reset_ack_counter", 32'(counter), 32'd0);
    clearAcks();
    applyStimulus(0, 0, 0, 0, 20);
    checkOutput("idle_no_acks", 32'(acks), 32'd0);

    // up for exactly MIN_HOLD samples fires on the 4th.
    clearAcks();
    applyStimulus(1, 0, 0, 0, 3);
    checkOutput("up_before_fire", 32'(acks), 32'd0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("up_fire_ack", 32'(ack), 32'd1);
    checkOutput("up_fire_counter", 32'(counter), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("up_ack_one_cycle", 32'(ack), 32'd0);

    // up for MIN_HOLD-1 samples never fires.
    clearAcks();
    applyStimulus(1, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("short_press_acks", 32'(acks), 32'd0);
    checkOutput("short_press_counter", 32'(counter), 32'd1);

    // down twice: 1 -> 0 -> 15 (wrap).
    clearAcks();
    applyStimulus(0, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("down_to_zero", 32'(counter), 32'd0);
    clearAcks();
    applyStimulus(0, 1, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("down_wrap_counter", 32'(counter), 32'd15);
    checkOutput("down_wrap_acks", 32'(acks), 32'd1);

    // up held 10 edges: single increment, 15 wraps to 0.
    clearAcks();
    applyStimulus(1, 0, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("up_long_counter", 32'(counter), 32'd0);
    checkOutput("up_long_acks", 32'(acks), 32'd1);
    checkOutput("up_long_ack_step", 32'(ackStep), 32'd4);

    // load 9 held 6 edges; value changes to 3 after the fire edge.
    clearAcks();
    applyStimulus(0, 0, 1, 9, 4);
    applyStimulus(0, 0, 1, 3, 2);
    applyStimulus(0, 0, 0, 3, 2);
    checkOutput("load_counter", 32'(counter), 32'd9);
    checkOutput("load_acks", 32'(acks), 32'd1);
    checkOutput("load_ack_step", 32'(ackStep), 32'd4);

    // up and load together: load wins.
    clearAcks();
    applyStimulus(1, 0, 1, 5, 4);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("prio_counter", 32'(counter), 32'd5);
    checkOutput("prio_acks", 32'(acks), 32'd1);

    // down for 2 then up for 4: restart counting, single increment.
    clearAcks();
    applyStimulus(0, 1, 0, 0, 2);
    applyStimulus(1, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("switch_counter", 32'(counter), 32'd6);
    checkOutput("switch_acks", 32'(acks), 32'd1);
    checkOutput("switch_ack_step", 32'(ackStep), 32'd6);

    // Reset mid-press with up held through release.
    clearAcks();
    applyStimulus(1, 0, 0, 0, 2);
    reset = 1'b1;
    #1;
    checkOutput("midpress_reset_counter", 32'(counter), 32'd0);
    applyStimulus(1, 0, 0, 0, 2);
    reset = 1'b0;
    clearAcks();
    applyStimulus(1, 0, 0, 0, 5);
    checkOutput("held_thru_reset_acks", 32'(acks), 32'd1);
    checkOutput("held_thru_reset_step", 32'(ackStep), 32'd1);
    checkOutput("held_thru_reset_counter", 32'(counter), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    clearAcks();
    applyStimulus(1, 0, 0, 0, 4);
    checkOutput("repress_counter", 32'(counter), 32'd1);
    checkOutput("repress_ack", 32'(ack), 32'd1);

    // Reset while ack is high clears it asynchronously.
    reset = 1'b1;
    #1;
    checkOutput("reset_clears_ack", 32'(ack), 32'd0);
    checkOutput("reset_clears_counter", 32'(counter), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    reset = 1'b0;
    clearAcks();
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("final_reset_acks", 32'(acks), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
